// File: rtl/mem_sorter_pkg.sv
// mem_sorter_pkg
// Shared definitions for the mem_sorter block.
//   state_t : controller states, IDLE (host access) and SORT (bubble sort running).
package mem_sorter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SORT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_sorter_cmp.sv
// sort_cmp
// Combinational ordered compare-swap of one adjacent word pair.
// Ports:
//   a, b    : words at index j and j+1 (unsigned)
//   desc    : 0 = ascending order wanted, 1 = descending
//   swap    : pair is out of order and must be exchanged (equal words never swap)
//   lo_out  : word to store back at index j
//   hi_out  : word to store back at index j+1
module sort_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             desc,
    output logic             swap,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_out
);

    // Strict compares keep equal words in place, which makes the sort stable.
    assign swap   = desc ? (a < b) : (a > b);
    assign lo_out = swap ? b : a;
    assign hi_out = swap ? a : b;

endmodule

// File: rtl/mem_sorter.sv
// mem_sorter
// DEPTH x WIDTH register array with host write/read access while idle and an
// in-place bubble sort (one compare-swap per clock) started on request.
// Ports:
//   clk, nrst : clock (rising edge), asynchronous active-low reset
//   start     : begin sorting (taken only while ready)
//   desc      : sort order captured with start, 0 = ascending, 1 = descending
//   wr        : write strobe (taken only while ready)
//   addr      : shared read/write address
//   data_in   : write data
//   data_out  : registered read data, one cycle after addr, held during a sort
//   ready     : high while idle
//   done      : one-cycle pulse on the edge that performs the final compare
module mem_sorter
    import mem_sorter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       start,
    input  logic                       desc,
    input  logic                       wr,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       ready,
    output logic                       done
);

    localparam int ADDR_W = $clog2(DEPTH);
    // One extra bit so the pass counter can step past DEPTH-2 without wrapping.
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 2);

    state_t                       state, state_nxt;
    logic [DEPTH-1:0][WIDTH-1:0]  mem;
    logic [CNT_W-1:0]             pass_q, idx_q;
    logic                         desc_q, swapped_q, done_q;
    logic [WIDTH-1:0]             data_out_q;
    logic [ADDR_W-1:0]            idx_a, idx_b;
    logic                         swap, last_cmp, sort_end;
    logic [WIDTH-1:0]             lo_out, hi_out;

    assign idx_a    = idx_q[ADDR_W-1:0];
    assign idx_b    = ADDR_W'(idx_q + 1'b1);
    assign ready    = (state == IDLE);
    assign done     = done_q;
    assign data_out = data_out_q;

    sort_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a      (mem[idx_a]),
        .b      (mem[idx_b]),
        .desc   (desc_q),
        .swap   (swap),
        .lo_out (lo_out),
        .hi_out (hi_out)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Pass p ends when j reaches DEPTH-2-p. The sort finishes there if it was
    // the last pass or if nothing in the pass (including this compare) swapped.
    always_comb begin
        state_nxt = state;
        sort_end  = 1'b0;
        last_cmp  = (idx_q == (LAST - pass_q));
        case (state)
            IDLE: if (start) state_nxt = SORT;
            SORT: begin
                if (last_cmp && ((pass_q == LAST) || !(swapped_q || swap))) begin
                    sort_end  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mem        <= '0;
            data_out_q <= '0;
            pass_q     <= '0;
            idx_q      <= '0;
            desc_q     <= 1'b0;
            swapped_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= sort_end;
            if (state == IDLE) begin
                // Read sees the pre-edge array, so a same-edge write is not visible.
                data_out_q <= mem[addr];
                if (wr) mem[addr] <= data_in;
                if (start) begin
                    desc_q    <= desc;
                    pass_q    <= '0;
                    idx_q     <= '0;
                    swapped_q <= 1'b0;
                end
            end else begin
                mem[idx_a] <= lo_out;
                mem[idx_b] <= hi_out;
                if (last_cmp) begin
                    pass_q    <= pass_q + 1'b1;
                    idx_q     <= '0;
                    swapped_q <= 1'b0;
                end else begin
                    idx_q     <= idx_q + 1'b1;
                    swapped_q <= swapped_q | swap;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_sorter.sv
// tb_mem_sorter
// Directed and randomized checks of mem_sorter (WIDTH=8, DEPTH=8) against a
// behavioural model: expected contents come from queue sort, expected compare
// counts from counting bubble-sort passes on a copy of the data.
module tb_mem_sorter;

    typedef logic [7:0] arr_t [8];

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       start = 1'b0;
    logic       desc = 1'b0;
    logic       wr = 1'b0;
    logic [2:0] addr = '0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       ready;
    logic       done;

    int total  = 0;
    int passed = 0;

    mem_sorter #(.WIDTH(8), .DEPTH(8)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .start    (start),
        .desc     (desc),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ready    (ready),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic arr_t sorted(input arr_t a, input bit d);
        logic [7:0] q[$];
        arr_t r;
        for (int i = 0; i < 8; i++) q.push_back(a[i]);
        if (d) q.rsort();
        else   q.sort();
        for (int i = 0; i < 8; i++) r[i] = q[i];
        return r;
    endfunction

    function automatic int compare_count(input arr_t a, input bit d);
        arr_t       w = a;
        int         n = 0;
        bit         any;
        logic [7:0] t;
        for (int p = 0; p <= 6; p++) begin
            any = 1'b0;
            for (int j = 0; j <= 6 - p; j++) begin
                n++;
                if (d ? (w[j] < w[j+1]) : (w[j] > w[j+1])) begin
                    t = w[j]; w[j] = w[j+1]; w[j+1] = t;
                    any = 1'b1;
                end
            end
            if (!any) break;
        end
        return n;
    endfunction

    task automatic write_all(input arr_t a);
        for (int i = 0; i < 8; i++) begin
            wr = 1'b1; addr = 3'(i); data_in = a[i];
            tick();
        end
        wr = 1'b0;
    endtask

    task automatic read_check(input string tag, input arr_t exp);
        for (int i = 0; i < 8; i++) begin
            addr = 3'(i);
            tick();
            chk($sformatf("%s[%0d]", tag, i), data_out, exp[i]);
        end
    endtask

    // Starts a sort, flips desc after acceptance, optionally tries a write to
    // address 0 mid-sort, and measures edges from acceptance to done.
    task automatic run_sort(input string tag, input bit d, input int exp_n, input bit inject);
        int n;
        bit got;
        desc = d; start = 1'b1;
        tick();
        start = 1'b0; desc = ~d;
        chk({tag, "_busy"}, ready, 1'b0);
        n = 0; got = 1'b0;
        while (n < 60 && !got) begin
            if (inject && n == 3) begin wr = 1'b1; addr = 3'd0; data_in = 8'h55; start = 1'b1; end
            else begin wr = 1'b0; start = 1'b0; end
            tick();
            n++;
            if (done) got = 1'b1;
        end
        wr = 1'b0; start = 1'b0;
        chk({tag, "_done_seen"}, got, 1'b1);
        chk({tag, "_edges"}, n, exp_n);
        chk({tag, "_ready_at_done"}, ready, 1'b1);
        tick();
        chk({tag, "_done_low"}, done, 1'b0);
    endtask

    initial begin
        arr_t a, zeros;
        bit   d;
        bit   saw_done;
        for (int i = 0; i < 8; i++) zeros[i] = 8'h00;

        // Reset state
        #2;
        chk("rst_ready", ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_data_out", data_out, 8'h00);
        @(posedge clk); #1;
        nrst = 1'b1;
        read_check("rst_read", zeros);

        // Mixed data ascending, then descending
        a = '{8'h07, 8'h03, 8'h05, 8'h01, 8'h08, 8'h02, 8'h06, 8'h04};
        write_all(a);
        run_sort("mix_asc", 1'b0, compare_count(a, 1'b0), 1'b0);
        read_check("mix_asc_rd", sorted(a, 1'b0));
        write_all(a);
        run_sort("mix_desc", 1'b1, compare_count(a, 1'b1), 1'b0);
        read_check("mix_desc_rd", sorted(a, 1'b1));

        // Worst case: reverse-ordered input, ascending
        a = '{8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        write_all(a);
        run_sort("rev_asc", 1'b0, 28, 1'b0);
        read_check("rev_asc_rd", sorted(a, 1'b0));

        // Already ordered: early exit after one pass, array unchanged
        a = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        write_all(a);
        run_sort("ord_asc", 1'b0, 7, 1'b0);
        read_check("ord_asc_rd", a);

        // Unsigned extremes with duplicates; write attempt mid-sort is ignored
        a = '{8'hFF, 8'h00, 8'h80, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01};
        write_all(a);
        run_sort("dup_asc", 1'b0, compare_count(a, 1'b0), 1'b1);
        read_check("dup_asc_rd", '{8'h00, 8'h00, 8'h01, 8'h7F, 8'h80, 8'h80, 8'hFF, 8'hFF});

        // Randomized arrays and orders
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) a[i] = 8'($urandom_range(0, 255));
            if (r == 5) for (int i = 0; i < 8; i++) a[i] = 8'($urandom_range(0, 3));
            d = 1'($urandom_range(0, 1));
            write_all(a);
            run_sort($sformatf("rnd%0d", r), d, compare_count(a, d), 1'b0);
            read_check($sformatf("rnd%0d_rd", r), sorted(a, d));
        end

        // Reset during compare 10 of a reverse-order sort
        a = '{8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        write_all(a);
        desc = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        saw_done = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_early_done", saw_done, 1'b0);
        chk("abort_busy", ready, 1'b0);
        nrst = 1'b0;
        #1;
        chk("abort_ready", ready, 1'b1);
        chk("abort_done", done, 1'b0);
        chk("abort_data_out", data_out, 8'h00);
        tick();
        chk("abort_done_held", done, 1'b0);
        nrst = 1'b1;
        read_check("abort_rd", zeros);
        chk("abort_final_done", done, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_sorter.md
MEM_SORTER -- requirements
Module: mem_sorter

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits, unsigned, >=1.
REQ-002 Parameter DEPTH, default 8, number of stored words, power of two, >=2.
REQ-003 Localparam ADDR_W = $clog2(DEPTH), address width.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 nrst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request to sort the stored array, sampled only while ready=1.
REQ-007 desc  input  1  sort order, 0=ascending, 1=descending, sampled with an accepted start.
REQ-008 wr  input  1  write strobe, honoured only while ready=1.
REQ-009 addr  input  ADDR_W  shared read/write address.
REQ-010 data_in  input  WIDTH  write data.
REQ-011 data_out  output  WIDTH  registered read data.
REQ-012 ready  output  1  high in IDLE; accepts wr/start/reads.
REQ-013 done  output  1  one-cycle pulse marking sort completion.

Function
REQ-014 Storage: DEPTH x WIDTH register array, only modified by writes and compare-swap steps.
REQ-015 Write: at an edge with ready=1 and wr=1, mem[addr] <= data_in.
REQ-016 Read: at every edge with ready=1, data_out <= mem[addr] (post-edge array value not visible, 1-cycle latency); data_out holds while ready=0.
REQ-017 FSM states IDLE and SORT; IDLE->SORT on edge with ready=1 and start=1 (edge E0); ready=0 from E0.
REQ-018 start and wr at the same edge: write performed and start accepted; sort includes the written word.
REQ-019 desc latched at E0; changes to desc during SORT have no effect.
REQ-020 SORT: bubble sort, exactly one compare-swap per clock, pass p (0..DEPTH-2) compares index pairs j,j+1 for j=0..DEPTH-2-p.
REQ-021 Swap condition: ascending mem[j]>mem[j+1]; descending mem[j]<mem[j+1]; unsigned compare; equal words never swapped (stable).
REQ-022 Early exit: a pass with no swap ends the sort at its last compare; otherwise sort ends after pass DEPTH-2.
REQ-023 At the edge performing the final compare (En): state->IDLE, ready=1, done=1; done=0 at En+1.
REQ-024 Compare count n: already-ordered input n=DEPTH-1; worst case n=DEPTH*(DEPTH-1)/2 (28 for DEPTH=8).
REQ-025 wr and start ignored during SORT; addr ignored during SORT.
REQ-026 Pass and index counters wide enough for DEPTH without wrap; reset to 0 on every accepted start.

Reset
REQ-027 nrst low: immediately state=IDLE, ready=1, done=0, data_out=0, all array words=0, counters=0, latched desc=0.
REQ-028 Reset mid-sort aborts the sort with no done pulse; first edge after release behaves as IDLE.

Structure
REQ-029 Package mem_sorter_pkg holds the state enum typedef (IDLE, SORT).
REQ-030 One combinational sub-module sort_cmp (params WIDTH; inputs a, b, desc; outputs swap, lo_out, hi_out) performs the ordered compare-swap.

Verification (WIDTH=8, DEPTH=8)
REQ-031 Assert nrst -> ready=1, done=0, data_out=0x00; reading all 8 addresses returns 0x00.
REQ-032 Write 07,03,05,01,08,02,06,04 to 0..7, start desc=0 -> done pulse with ready=1, readback 01..08 at addresses 0..7, data 1 cycle after addr.
REQ-033 Same data, desc=1 -> readback 08..01; reverse-ordered input 08..01 with desc=0 -> done exactly 28 edges after E0.
REQ-034 Input 01..08, desc=0 -> done exactly 7 edges after E0, array unchanged.
REQ-035 Input FF,00,80,80,7F,00,FF,01 ascending -> 00,00,01,7F,80,80,FF,FF (unsigned, duplicates kept); wr to addr 0 of 0x55 mid-sort -> ignored.
REQ-036 nrst low at compare 10 of a reverse-order sort -> ready=1 at once, no done pulse, all words 0x00.
